// File: rtl/ssd_pkg.sv
// Shared constants for the seven-segment scan driver: segment patterns,
// blank levels and a prescaler sizing helper.
package ssd_pkg;

  // Active-low cathode pattern that turns every segment off.
  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Anode level for an unlit digit (anodes are active-low).
  localparam logic AN_OFF = 1'b1;

  // Active-low segment patterns for hex digits 0..F, bit0 = a ... bit6 = g.
  localparam logic [6:0] SEG_HEX [0:15] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  // Smallest prescaler width able to count 0..div-1.
  function automatic int cnt_width(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/ssd_hex_decode.sv
// Combinational nibble to active-low seven-segment decoder.
module ssd_hex_decode
  import ssd_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);

  // Table lookup of the segment pattern for the selected nibble.
  always_comb begin
    seg_o = SEG_HEX[nib_i];
  end

endmodule

// File: rtl/ssd_scan_mux.sv
// Time-multiplexed driver for an N-digit seven-segment display. One digit is
// driven per refresh slot; new values are taken only at frame boundaries so a
// frame never shows a mix of old and new digits.
module ssd_scan_mux
  import ssd_pkg::*;
#(
  parameter int DIGITS      = 8,
  parameter int REFRESH_DIV = 100000,
  parameter int CNT_W       = 17
) (
  input  logic                  ssd_scan_mux_port_clk,
  input  logic                  ssd_scan_mux_port_rst,
  input  logic                  ssd_scan_mux_port_load,
  input  logic [4*DIGITS-1:0]   ssd_scan_mux_port_val,
  input  logic [DIGITS-1:0]     ssd_scan_mux_port_dp,
  input  logic [DIGITS-1:0]     ssd_scan_mux_port_digit_en,
  input  logic                  ssd_scan_mux_port_blank_lz,
  output logic [6:0]            ssd_scan_mux_port_cc,
  output logic                  ssd_scan_mux_port_odp,
  output logic [DIGITS-1:0]     ssd_scan_mux_port_an,
  output logic                  ssd_scan_mux_port_frame_tick
);

  localparam int                 IDX_W      = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0]   PRESC_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(DIGITS - 1);
  localparam logic [DIGITS-1:0]  AN_ALL_OFF = {DIGITS{AN_OFF}};

  // Timing state
  logic [CNT_W-1:0]    presc_q, presc_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                ftick_q, ftick_d;

  // Pending (written by load) and shadow (displayed) value registers
  logic [4*DIGITS-1:0] pend_val_q, pend_val_d;
  logic [DIGITS-1:0]   pend_dp_q, pend_dp_d;
  logic                pend_vld_q, pend_vld_d;
  logic [4*DIGITS-1:0] shad_val_q, shad_val_d;
  logic [DIGITS-1:0]   shad_dp_q, shad_dp_d;

  // Output registers
  logic [DIGITS-1:0]   an_q, an_d;
  logic [6:0]          cc_q, cc_d;
  logic                odp_q, odp_d;

  // Combinational helpers
  logic                slot_tick_s;
  logic                boundary_s;
  logic [3:0]          nib_s;
  logic [6:0]          seg_s;
  logic [DIGITS-1:0]   upper_zero_s;
  logic                en_s;
  logic                dp_s;
  logic                uz_s;
  logic                shown_s;

  // Prescaler and scan index advance; frame tick is looked ahead one cycle
  // so the registered pulse lines up with the boundary cycle itself.
  always_comb begin
    slot_tick_s = (presc_q == PRESC_LAST);
    boundary_s  = slot_tick_s && (idx_q == IDX_LAST);
    if (slot_tick_s) begin
      presc_d = '0;
      if (idx_q == IDX_LAST) begin
        idx_d = '0;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end else begin
      presc_d = presc_q + CNT_W'(1);
      idx_d   = idx_q;
    end
    ftick_d = (presc_d == PRESC_LAST) && (idx_d == IDX_LAST);
  end

  // Pending capture and frame-boundary transfer into the shadow registers;
  // a load coinciding with a boundary bypasses pending.
  always_comb begin
    pend_val_d = pend_val_q;
    pend_dp_d  = pend_dp_q;
    pend_vld_d = pend_vld_q;
    shad_val_d = shad_val_q;
    shad_dp_d  = shad_dp_q;
    if (boundary_s) begin
      pend_vld_d = 1'b0;
      if (ssd_scan_mux_port_load) begin
        shad_val_d = ssd_scan_mux_port_val;
        shad_dp_d  = ssd_scan_mux_port_dp;
      end else if (pend_vld_q) begin
        shad_val_d = pend_val_q;
        shad_dp_d  = pend_dp_q;
      end else begin
        shad_val_d = shad_val_q;
        shad_dp_d  = shad_dp_q;
      end
    end else if (ssd_scan_mux_port_load) begin
      pend_val_d = ssd_scan_mux_port_val;
      pend_dp_d  = ssd_scan_mux_port_dp;
      pend_vld_d = 1'b1;
    end else begin
      pend_vld_d = pend_vld_q;
    end
  end

  // For each digit: are this nibble and every more-significant nibble zero?
  always_comb begin
    upper_zero_s = '0;
    for (int i = 0; i < DIGITS; i++) begin
      upper_zero_s[i] = ((shad_val_q >> (4 * i)) == {(4*DIGITS){1'b0}});
    end
  end

  // Select the current digit's nibble and per-digit attributes.
  always_comb begin
    nib_s = shad_val_q[{idx_q, 2'b00} +: 4];
    en_s  = ssd_scan_mux_port_digit_en[idx_q];
    dp_s  = shad_dp_q[idx_q];
    uz_s  = upper_zero_s[idx_q];
  end

  ssd_hex_decode u_dec (
    .nib_i (nib_s),
    .seg_o (seg_s)
  );

  // Next output values: disabled or zero-suppressed digits keep their anode
  // off; only a disabled digit also forces its decimal point off.
  always_comb begin
    shown_s = en_s && !(ssd_scan_mux_port_blank_lz && (idx_q != '0) && uz_s);
    if (shown_s) begin
      an_d = ~(DIGITS'(1'b1) << idx_q);
      cc_d = seg_s;
    end else begin
      an_d = AN_ALL_OFF;
      cc_d = SEG_OFF;
    end
    if (en_s) begin
      odp_d = ~dp_s;
    end else begin
      odp_d = 1'b1;
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge ssd_scan_mux_port_clk or posedge ssd_scan_mux_port_rst) begin
    if (ssd_scan_mux_port_rst) begin
      presc_q    <= '0;
      idx_q      <= '0;
      ftick_q    <= 1'b0;
      pend_val_q <= '0;
      pend_dp_q  <= '0;
      pend_vld_q <= 1'b0;
      shad_val_q <= '0;
      shad_dp_q  <= '0;
      an_q       <= AN_ALL_OFF;
      cc_q       <= SEG_OFF;
      odp_q      <= 1'b1;
    end else begin
      presc_q    <= presc_d;
      idx_q      <= idx_d;
      ftick_q    <= ftick_d;
      pend_val_q <= pend_val_d;
      pend_dp_q  <= pend_dp_d;
      pend_vld_q <= pend_vld_d;
      shad_val_q <= shad_val_d;
      shad_dp_q  <= shad_dp_d;
      an_q       <= an_d;
      cc_q       <= cc_d;
      odp_q      <= odp_d;
    end
  end

  assign ssd_scan_mux_port_an         = an_q;
  assign ssd_scan_mux_port_cc         = cc_q;
  assign ssd_scan_mux_port_odp        = odp_q;
  assign ssd_scan_mux_port_frame_tick = ftick_q;

endmodule
